// File: rtl/hex_readout_pkg.sv
// Shared types and constants for the hex/decimal seven-segment readout.
// Segment patterns are active-low, bit order g..a.
package hex_readout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_B    = 7'h03;
  localparam logic [6:0] SEG_C    = 7'h46;
  localparam logic [6:0] SEG_D    = 7'h21;
  localparam logic [6:0] SEG_E    = 7'h06;
  localparam logic [6:0] SEG_F    = 7'h0E;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Decimal digits needed for a binary value of width w.
  function automatic int bcd_digits(input int w);
    return (w * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/hex_readout_seg7_decode.sv
// Nibble to active-low seven-segment glyph (0-9, A-F).
module seg7_decode
  import hex_readout_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_readout.sv
// Multi-digit seven-segment readout: periodic/on-demand capture, hex or
// double-dabble decimal conversion, leading-zero blanking, overflow dashes, blink.
module hex_readout
  import hex_readout_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int VALUE_WIDTH   = 16,
  parameter int REFRESH_TICKS = 5_000_000,
  parameter int BLINK_TICKS   = 12_500_000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [VALUE_WIDTH-1:0]  value,
  input  logic                    mode,
  input  logic                    blank_leading,
  input  logic                    blink_en,
  input  logic                    update_req,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    busy,
  output logic                    overflow
);

  localparam int BCD_D = bcd_digits(VALUE_WIDTH);
  localparam int BCD_W = 4 * BCD_D;
  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam int MAX_W = (DIG_W > BCD_W) ? DIG_W : BCD_W;
  // Extra nibble keeps the overflow slice non-empty for every parameter set.
  localparam int PAD_W = ((MAX_W > VALUE_WIDTH) ? MAX_W : VALUE_WIDTH) + 4;
  localparam int RW    = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int BW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int CW    = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;

  state_t                         state, state_nxt;
  logic                           capture, pending, refresh_tick;
  logic [RW-1:0]                  rcnt;
  logic [BW-1:0]                  bcnt;
  logic                           phase;
  logic [VALUE_WIDTH-1:0]         cap_val, shreg;
  logic                           cap_mode, cap_blank;
  logic [BCD_W-1:0]               bcd, bcd_adj;
  logic [CW-1:0]                  bit_cnt;
  logic [PAD_W-1:0]               src;
  logic                           ovf_c, ovf;
  logic [NUM_DIGITS-1:0][6:0]     pat, pat_nxt;

  // Free-running refresh timebase, independent of the FSM.
  assign refresh_tick = (rcnt == RW'(REFRESH_TICKS - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset || refresh_tick) rcnt <= '0;
    else                       rcnt <= rcnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_TICKS - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  // A live update_req is honoured in the same IDLE cycle it arrives; ticks
  // seen outside IDLE are simply lost.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: if (refresh_tick || pending || update_req) begin
        capture   = 1'b1;
        state_nxt = mode ? CONVERT : LOAD;
      end
      CONVERT: if (bit_cnt == CW'(VALUE_WIDTH - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_D; d++)
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      cap_val   <= '0;
      cap_mode  <= 1'b0;
      cap_blank <= 1'b0;
      shreg     <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      pat       <= {NUM_DIGITS{SEG_OFF}};
      ovf       <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= capture ? 1'b0 : (pending | update_req);
      if (capture) begin
        cap_val   <= value;
        cap_mode  <= mode;
        cap_blank <= blank_leading;
        shreg     <= value;
        bcd       <= '0;
        bit_cnt   <= '0;
      end else if (state == CONVERT) begin
        bcd     <= (bcd_adj << 1) | BCD_W'(shreg[VALUE_WIDTH-1]);
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == LOAD) begin
        pat <= pat_nxt;
        ovf <= ovf_c;
      end
    end
  end

  assign src   = cap_mode ? PAD_W'(bcd) : PAD_W'(cap_val);
  assign ovf_c = |src[PAD_W-1:DIG_W];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic [6:0] glyph;
    logic       lead;
    seg7_decode u_dec (.nibble(src[4*k +: 4]), .seg(glyph));
    assign lead       = (k != 0) && cap_blank && (src[DIG_W-1:4*k] == '0);
    assign pat_nxt[k] = ovf_c ? SEG_DASH : (lead ? SEG_OFF : glyph);
  end

  assign segs     = (blink_en && phase) ? {(7*NUM_DIGITS){1'b1}} : pat;
  assign busy     = (state != IDLE);
  assign overflow = ovf;

endmodule

// File: tb/tb_hex_readout.sv
// Bench for hex_readout: 4- and 6-digit instances share stimulus and are checked
// against an arithmetic reference (powers of the radix, not shift-add-3).
module tb_hex_readout;
  localparam int VW = 16, RT = 8, BT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, mode, blank_leading, blink_en, update_req;
  logic [VW-1:0] value;
  logic [27:0]   segs4;
  logic [41:0]   segs6;
  logic          busy4, busy6, ovf4, ovf6;
  int            n_checks = 0, n_fail = 0, cyc = 0;
  logic [69:0]   last_s;
  logic [1:0]    last_o;

  hex_readout #(.NUM_DIGITS(4), .VALUE_WIDTH(VW), .REFRESH_TICKS(RT), .BLINK_TICKS(BT)) u_d4 (
    .CLOCK_50(clk), .reset(reset), .value(value), .mode(mode), .blank_leading(blank_leading),
    .blink_en(blink_en), .update_req(update_req), .segs(segs4), .busy(busy4), .overflow(ovf4));

  hex_readout #(.NUM_DIGITS(6), .VALUE_WIDTH(VW), .REFRESH_TICKS(RT), .BLINK_TICKS(BT)) u_d6 (
    .CLOCK_50(clk), .reset(reset), .value(value), .mode(mode), .blank_leading(blank_leading),
    .blink_en(blink_en), .update_req(update_req), .segs(segs6), .busy(busy6), .overflow(ovf6));

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Digit k is (v / radix^k) % radix; leading digits blank when v < radix^k.
  function automatic logic [41:0] model(input int nd, input int unsigned v, input bit m,
                                        input bit b, output bit ovf);
    int unsigned base, lim, p;
    logic [41:0] r;
    base = m ? 10 : 16;
    lim  = 1;
    for (int k = 0; k < nd; k++) lim *= base;
    ovf = (v >= lim);
    r   = '1;
    p   = 1;
    for (int k = 0; k < nd; k++) begin
      if (ovf)                     r[7*k +: 7] = 7'b0111111;
      else if (b && k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                         r[7*k +: 7] = glyph(int'((v / p) % base));
      p *= base;
    end
    return r;
  endfunction

  function automatic void expect_both(input int unsigned v, input bit m, input bit b,
                                      output logic [69:0] s, output logic [1:0] o);
    bit o4, o6;
    logic [41:0] e4, e6;
    e4 = model(4, v, m, b, o4);
    e6 = model(6, v, m, b, o6);
    s  = {e6, e4[27:0]};
    o  = {o6, o4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; update_req = 1'b0; blink_en = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    logic [69:0] es; logic [1:0] eo;
    value = 16'h1234; mode = 1'b0; blank_leading = 1'b0; blink_en = 1'b0; update_req = 1'b0;
    reset = 1'b1;
    step(); step();
    n_checks++;
    if ({segs6, segs4} !== {70{1'b1}} || {busy6, busy4, ovf6, ovf4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: segs=%h busy/ovf=%b want all-off 0000", {segs6, segs4}, {busy6, busy4, ovf6, ovf4});
    end
    reset = 1'b0; cyc = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_checks++;
      if ({busy6, busy4} !== 2'b00 || {segs6, segs4} !== {70{1'b1}}) begin
        n_fail++;
        $display("FAIL no_early_capture: cyc=%0d busy=%b segs=%h want 00 all-off", cyc, {busy6, busy4}, {segs6, segs4});
      end
    end
    step();
    n_checks++;
    if ({busy6, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_refresh_capture: busy=%b want 11", {busy6, busy4});
    end
    step();
    expect_both(16'h1234, 1'b0, 1'b0, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es || {ovf6, ovf4} !== eo) begin
      n_fail++;
      $display("FAIL refresh_load: segs=%h ovf=%b want %h %b", {segs6, segs4}, {ovf6, ovf4}, es, eo);
    end
  endtask

  task automatic test_hex();
    logic [69:0] es; logic [1:0] eo;
    do_reset();
    value = 16'hBEEF; mode = 1'b0; blank_leading = 1'b0;
    step();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    n_checks++;
    if ({busy6, busy4} !== 2'b11 || {segs6, segs4} !== {70{1'b1}}) begin
      n_fail++;
      $display("FAIL hex_load_cycle: busy=%b segs=%h want 11 all-off", {busy6, busy4}, {segs6, segs4});
    end
    step();
    expect_both(16'hBEEF, 1'b0, 1'b0, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es || {ovf6, ovf4} !== eo || {busy6, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL hex_beef: segs=%h ovf=%b busy=%b want %h %b 00", {segs6, segs4}, {ovf6, ovf4}, {busy6, busy4}, es, eo);
    end
    step();
    n_checks++;
    if ({busy6, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL hex_busy_one_cycle: busy=%b want 00", {busy6, busy4});
    end
  endtask

  // Request one capture and check both the cycle before and the cycle of the update.
  task automatic test_capture(input logic [15:0] v, input bit m, input bit b, input bit fresh,
                              input string tag);
    logic [69:0] es; logic [1:0] eo; int lat;
    if (fresh) begin
      do_reset();
      last_s = {70{1'b1}}; last_o = 2'b00;
      step();
    end
    lat   = m ? VW + 2 : 2;
    value = v; mode = m; blank_leading = b; update_req = 1'b1;
    step();
    update_req = 1'b0; value = 16'($urandom); mode = 1'($urandom); blank_leading = 1'($urandom);
    for (int i = 2; i < lat; i++) step();
    n_checks++;
    if ({segs6, segs4} !== last_s || {ovf6, ovf4} !== last_o || {busy6, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_before_update: segs=%h ovf=%b busy=%b want %h %b 11", tag, {segs6, segs4}, {ovf6, ovf4}, {busy6, busy4}, last_s, last_o);
    end
    step();
    expect_both(v, m, b, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es || {ovf6, ovf4} !== eo || {busy6, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_result: v=%0d m=%0b b=%0b segs=%h ovf=%b busy=%b want %h %b 00", tag, v, m, b, {segs6, segs4}, {ovf6, ovf4}, {busy6, busy4}, es, eo);
    end
    last_s = es; last_o = eo;
  endtask

  task automatic test_decimal();
    test_capture(16'd12345, 1'b1, 1'b1, 1'b1, "dec_12345");
    test_capture(16'd9999,  1'b1, 1'b0, 1'b1, "dec_9999");
    test_capture(16'd10000, 1'b1, 1'b1, 1'b1, "dec_10000");
  endtask

  task automatic test_overflow();
    test_capture(16'd65535, 1'b1, 1'b0, 1'b1, "ovf_65535");
    test_capture(16'd0,     1'b1, 1'b1, 1'b0, "ovf_clear_0");
  endtask

  task automatic test_coincide();
    logic [69:0] es; logic [1:0] eo;
    do_reset();
    value = 16'h00A5; mode = 1'b0; blank_leading = 1'b1;
    repeat (7) step();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    n_checks++;
    if ({busy6, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL coincide_capture: busy=%b want 11", {busy6, busy4});
    end
    step();
    expect_both(16'h00A5, 1'b0, 1'b1, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es || {busy6, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL coincide_result: segs=%h busy=%b want %h 00", {segs6, segs4}, {busy6, busy4}, es);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({busy6, busy4} !== 2'b00) begin
        n_fail++;
        $display("FAIL coincide_single: cyc=%0d busy=%b want 00", cyc, {busy6, busy4});
      end
    end
  endtask

  task automatic test_pending();
    logic [69:0] es; logic [1:0] eo;
    int r4, r6; logic p4, p6;
    do_reset();
    value = 16'd4321; mode = 1'b1; blank_leading = 1'b0;
    step();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    p4 = busy4; p6 = busy6; r4 = 0; r6 = 0;
    for (int c = 2; c < 39; c++) begin
      update_req = (c == 4 || c == 6 || c == 10);
      step();
      if (busy4 && !p4) r4++;
      if (busy6 && !p6) r6++;
      p4 = busy4; p6 = busy6;
    end
    n_checks++;
    if (r4 != 1 || r6 != 1) begin
      n_fail++;
      $display("FAIL pending_collapse: extra captures d4=%0d d6=%0d want 1 1", r4, r6);
    end
    expect_both(16'd4321, 1'b1, 1'b0, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es || {busy6, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL pending_result: segs=%h busy=%b want %h 00", {segs6, segs4}, {busy6, busy4}, es);
    end
  endtask

  task automatic test_reset_abort();
    logic [69:0] es; logic [1:0] eo;
    do_reset();
    value = 16'h5A5A; mode = 1'b0; blank_leading = 1'b0;
    step();
    update_req = 1'b1; step(); update_req = 1'b0;
    step();
    expect_both(16'h5A5A, 1'b0, 1'b0, es, eo);
    n_checks++;
    if ({segs6, segs4} !== es) begin
      n_fail++;
      $display("FAIL abort_preload: segs=%h want %h", {segs6, segs4}, es);
    end
    mode = 1'b1; value = 16'd777;
    update_req = 1'b1; step(); update_req = 1'b0;
    step();
    update_req = 1'b1; step(); update_req = 1'b0;
    step(); step();
    n_checks++;
    if ({busy6, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_in_convert: busy=%b want 11", {busy6, busy4});
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({segs6, segs4} !== {70{1'b1}} || {busy6, busy4, ovf6, ovf4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_reset_state: segs=%h busy/ovf=%b want all-off 0000", {segs6, segs4}, {busy6, busy4, ovf6, ovf4});
    end
    reset = 1'b0; cyc = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_checks++;
      if ({busy6, busy4} !== 2'b00 || {segs6, segs4} !== {70{1'b1}}) begin
        n_fail++;
        $display("FAIL abort_pending_cleared: cyc=%0d busy=%b segs=%h want 00 all-off", cyc, {busy6, busy4}, {segs6, segs4});
      end
    end
    step();
    n_checks++;
    if ({busy6, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_refresh_after: busy=%b want 11", {busy6, busy4});
    end
  endtask

  task automatic test_blink();
    logic [69:0] es, ex; logic [1:0] eo;
    do_reset();
    value = 16'h00C3; mode = 1'b0; blank_leading = 1'b0;
    step();
    update_req = 1'b1; step(); update_req = 1'b0;
    step();
    expect_both(16'h00C3, 1'b0, 1'b0, es, eo);
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      ex = (((cyc / BT) % 2) == 1) ? {70{1'b1}} : es;
      n_checks++;
      if ({segs6, segs4} !== ex) begin
        n_fail++;
        $display("FAIL blink_on: cyc=%0d segs=%h want %h", cyc, {segs6, segs4}, ex);
      end
    end
    blink_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if ({segs6, segs4} !== es) begin
        n_fail++;
        $display("FAIL blink_off: cyc=%0d segs=%h want %h", cyc, {segs6, segs4}, es);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v; bit m, b;
    for (int i = 0; i < 24; i++) begin
      case (i % 6)
        0: v = 16'd9999;
        1: v = 16'd10000;
        2: v = 16'($urandom_range(0, 255));
        default: v = 16'($urandom);
      endcase
      m = (i % 6 < 2) ? 1'b1 : 1'($urandom);
      b = 1'($urandom);
      test_capture(v, m, b, 1'b1, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; value = '0; mode = 1'b0; blank_leading = 1'b0; blink_en = 1'b0; update_req = 1'b0;
    last_s = {70{1'b1}}; last_o = 2'b00;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_coincide();
    test_pending();
    test_reset_abort();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
